uk101_video_timing: RTL and testbench



---
 rtl/uk101_video_pkg.sv | 28 ++
 rtl/ce_divider.sv | 42 ++++
 rtl/uk101_video_timing.sv | 160 ++++++++++++++++
 tb/tb_uk101_video_timing.sv | 127 ++++++++++++
 4 files changed

// File: rtl/uk101_video_pkg.sv
// Shared timing defaults, mode encoding and counter sizing for the UK101 video path.
package uk101_video_pkg;

    localparam int DEF_CLK_DIV      = 5;
    localparam int DEF_H_TOTAL      = 640;
    localparam int DEF_H_ACTIVE0    = 512;
    localparam int DEF_H_ACTIVE1    = 384;
    localparam int DEF_H_SYNC_START = 560;
    localparam int DEF_H_SYNC_LEN   = 48;
    localparam int DEF_V_TOTAL      = 312;
    localparam int DEF_V_ACTIVE0    = 256;
    localparam int DEF_V_ACTIVE1    = 256;
    localparam int DEF_V_SYNC_START = 272;
    localparam int DEF_V_SYNC_LEN   = 4;
    localparam bit DEF_HS_POL       = 1'b0;
    localparam bit DEF_VS_POL       = 1'b0;

    typedef enum logic {
        MODE_64X32 = 1'b0,
        MODE_48X16 = 1'b1
    } video_mode_e;

    // Bits needed to hold 0..n-1; never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running divide-by-DIV clock enable: one-clock pulse every DIV clocks.
module ce_divider
    import uk101_video_pkg::*;
#(
    parameter int DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic n_reset,
    output logic ce
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce_q, ce_d;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("ce_divider: DIV must be at least 2");
        end
    endgenerate

    // The enable is registered, so it appears on the edge that wraps the counter.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        ce_d  = (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/uk101_video_timing.sv
// Pixel-enable and raster timing generator with two active windows selected at frame wrap.
module uk101_video_timing
    import uk101_video_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE0    = DEF_H_ACTIVE0,
    parameter int H_ACTIVE1    = DEF_H_ACTIVE1,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE0    = DEF_V_ACTIVE0,
    parameter int V_ACTIVE1    = DEF_V_ACTIVE1,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
    parameter bit HS_POL       = DEF_HS_POL,
    parameter bit VS_POL       = DEF_VS_POL
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           mode,
    output logic                           ce_pix,
    output logic [cnt_width(H_TOTAL)-1:0]  hcount,
    output logic [cnt_width(V_TOTAL)-1:0]  vcount,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           hblank,
    output logic                           vblank,
    output logic                           de,
    output logic                           line_start,
    output logic                           frame_start,
    output logic                           mode_active
);

    localparam int HW = cnt_width(H_TOTAL);
    localparam int VW = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HA0    = HW'(H_ACTIVE0);
    localparam logic [HW-1:0] HA1    = HW'(H_ACTIVE1);
    localparam logic [VW-1:0] VA0    = VW'(V_ACTIVE0);
    localparam logic [VW-1:0] VA1    = VW'(V_ACTIVE1);
    // Sync window ends may equal the total, which can need one more bit.
    localparam logic [HW:0]   HS_BEG = (HW + 1)'(H_SYNC_START);
    localparam logic [HW:0]   HS_END = (HW + 1)'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [VW:0]   VS_BEG = (VW + 1)'(V_SYNC_START);
    localparam logic [VW:0]   VS_END = (VW + 1)'(V_SYNC_START + V_SYNC_LEN);

    generate
        if (CLK_DIV < 2) begin : g_chk_div
            $error("uk101_video_timing: CLK_DIV must be at least 2");
        end
        if (H_ACTIVE0 > H_SYNC_START || H_ACTIVE1 > H_SYNC_START ||
            H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_chk_h
            $error("uk101_video_timing: inconsistent horizontal timing");
        end
        if (V_ACTIVE0 > V_SYNC_START || V_ACTIVE1 > V_SYNC_START ||
            V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_chk_v
            $error("uk101_video_timing: inconsistent vertical timing");
        end
    endgenerate

    logic ce_w;

    ce_divider #(
        .DIV (CLK_DIV)
    ) u_ce_divider (
        .clk     (clk),
        .n_reset (n_reset),
        .ce      (ce_w)
    );

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    video_mode_e   mode_active_q, mode_active_d;
    logic          mode_meta_q, mode_meta_d;
    logic          mode_sync_q, mode_sync_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          de_q, de_d;
    logic [HW-1:0] ha;
    logic [VW-1:0] va;
    logic          hs_on, vs_on;

    // Decode is taken from the next counter values so outputs move with the counters.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        mode_active_d = mode_active_q;
        mode_meta_d   = mode;
        mode_sync_d   = mode_meta_q;

        if (ce_w) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    mode_active_d = video_mode_e'(mode_sync_q);
                end else begin
                    vcount_d = vcount_q + VW'(1);
                end
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end

        ha       = (mode_active_d == MODE_48X16) ? HA1 : HA0;
        va       = (mode_active_d == MODE_48X16) ? VA1 : VA0;
        hblank_d = (hcount_d >= ha);
        vblank_d = (vcount_d >= va);
        de_d     = ~(hblank_d | vblank_d);
        hs_on    = ({1'b0, hcount_d} >= HS_BEG) && ({1'b0, hcount_d} < HS_END);
        vs_on    = ({1'b0, vcount_d} >= VS_BEG) && ({1'b0, vcount_d} < VS_END);
        hsync_d  = hs_on ? HS_POL : ~HS_POL;
        vsync_d  = vs_on ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            mode_active_q <= MODE_64X32;
            mode_meta_q   <= 1'b0;
            mode_sync_q   <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b1;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            mode_active_q <= mode_active_d;
            mode_meta_q   <= mode_meta_d;
            mode_sync_q   <= mode_sync_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
        end
    end

    assign ce_pix      = ce_w;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign mode_active = mode_active_q;
    // Strobes mark the enable cycle of pixel 0, which is the last clock that pixel is held.
    assign line_start  = ce_w && (hcount_q == '0);
    assign frame_start = ce_w && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_uk101_video_timing.sv
// Randomised mode toggles and resets against a time-based raster model.
module tb_uk101_video_timing;

    localparam int D   = 3;
    localparam int HT  = 32;
    localparam int HA0 = 24;
    localparam int HA1 = 16;
    localparam int HSS = 28;
    localparam int HSL = 4;
    localparam int VT  = 16;
    localparam int VA0 = 12;
    localparam int VA1 = 8;
    localparam int VSS = 13;
    localparam int VSL = 3;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam int N_CYC = 48000;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       mode;
    logic       ce_pix, hsync, vsync, hblank, vblank, de;
    logic       line_start, frame_start, mode_active;
    logic [4:0] hcount;
    logic [3:0] vcount;

    int   tests = 0;
    int   fails = 0;
    int   t;
    logic mode_at [0:65535];

    always #5 clk = ~clk;

    uk101_video_timing #(
        .CLK_DIV (D), .H_TOTAL (HT), .H_ACTIVE0 (HA0), .H_ACTIVE1 (HA1),
        .H_SYNC_START (HSS), .H_SYNC_LEN (HSL), .V_TOTAL (VT),
        .V_ACTIVE0 (VA0), .V_ACTIVE1 (VA1), .V_SYNC_START (VSS),
        .V_SYNC_LEN (VSL), .HS_POL (HSP), .VS_POL (VSP)
    ) dut (
        .clk (clk), .n_reset (n_reset), .mode (mode), .ce_pix (ce_pix),
        .hcount (hcount), .vcount (vcount), .hsync (hsync), .vsync (vsync),
        .hblank (hblank), .vblank (vblank), .de (de),
        .line_start (line_start), .frame_start (frame_start),
        .mode_active (mode_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // Expected state after t clock edges since reset release, from elapsed pixel count.
    function automatic void model(input int tt, output int h, output int v, output logic [8:0] fl);
        int   n, f, ha, va;
        logic ce, m, hb, vb, hs, vs;
        ce = (tt >= D) && (tt % D == 0);
        n  = (tt >= 1) ? (tt - 1) / D : 0;
        h  = n % HT;
        v  = (n / HT) % VT;
        f  = n / (HT * VT);
        m  = (f == 0) ? 1'b0 : mode_at[f * HT * VT * D - 1];
        ha = m ? HA1 : HA0;
        va = m ? VA1 : VA0;
        hb = (h >= ha);
        vb = (v >= va);
        hs = (h >= HSS && h < HSS + HSL) ? HSP : ~HSP;
        vs = (v >= VSS && v < VSS + VSL) ? VSP : ~VSP;
        fl = {ce, hs, vs, hb, vb, ~(hb | vb), ce && h == 0, ce && h == 0 && v == 0, m};
    endfunction

    function automatic logic [8:0] flags();
        return {ce_pix, hsync, vsync, hblank, vblank, de, line_start, frame_start, mode_active};
    endfunction

    task automatic check_cycle();
        int h, v;
        logic [8:0] fl;
        model(t, h, v, fl);
        check("hcount", 32'(hcount), 32'(h));
        check("vcount", 32'(vcount), 32'(v));
        check("flags{ce,hs,vs,hb,vb,de,ls,fs,ma}", 32'(flags()), 32'(fl));
    endtask

    task automatic check_reset(input string tag);
        logic [8:0] exp_fl;
        exp_fl = {1'b0, ~HSP, ~VSP, 6'b001000};
        check({tag, "_hcount"}, 32'(hcount), 32'd0);
        check({tag, "_vcount"}, 32'(vcount), 32'd0);
        check({tag, "_flags"}, 32'(flags()), 32'(exp_fl));
    endtask

    initial begin
        int rst_a, rst_b;
        n_reset = 1'b0;
        mode    = 1'b0;
        t       = 0;
        rst_a   = 15000 + int'($urandom_range(0, 1500));
        rst_b   = 31000 + int'($urandom_range(0, 1500));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        n_reset = 1'b1;
        for (int cyc = 0; cyc < N_CYC && fails < 100; cyc++) begin
            @(posedge clk);
            t++;
            mode_at[t] = mode;
            @(negedge clk);
            check_cycle();
            if ($urandom_range(0, 399) == 0) mode = ~mode;
            if (cyc == rst_a || cyc == rst_b) begin
                #1 n_reset = 1'b0;
                #1 check_reset("async_rst");
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_reset("held_rst");
                n_reset = 1'b1;
                t = 0;
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
